// File: rtl/tx_sched_pkg.sv
// Shared constants for the UART TX frame scheduler: state encoding, requester IDs, default widths.
package tx_sched_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned B_BYTES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF = 16;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/tx_frame_sched_if.sv
// Requester and transmitter handshake bundle for tx_frame_sched.
// slave: the scheduler side; master: requesters plus transmitter side.
interface tx_frame_sched_if #(
    parameter int unsigned DATA_W  = tx_sched_pkg::DATA_W_DEF,
    parameter int unsigned B_BYTES = tx_sched_pkg::B_BYTES_DEF
);
    logic                        a_req;
    logic [DATA_W-1:0]           a_data;
    logic                        a_ack;
    logic                        b_req;
    logic [DATA_W*B_BYTES-1:0]   b_data;
    logic                        b_ack;
    logic [DATA_W-1:0]           tx_p_data;
    logic                        tx_data_valid;
    logic                        tx_busy;
    logic                        sched_idle;
    logic                        tx_err;

    modport slave (
        input  a_req, a_data, b_req, b_data, tx_busy,
        output a_ack, b_ack, tx_p_data, tx_data_valid, sched_idle, tx_err
    );

    modport master (
        output a_req, a_data, b_req, b_data, tx_busy,
        input  a_ack, b_ack, tx_p_data, tx_data_valid, sched_idle, tx_err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser on update.
module rr_arb2
    import tx_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_id,
    output logic [1:0] grant_c
);
    logic ptr_q;
    logic other;

    // Pointer names the favoured requester; after a frame it favours the one that did not win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ptr_q <= REQ_A;
        else if (update) ptr_q <= ~upd_id;
    end

    // Favoured requester wins if it asks, otherwise the other one.
    always_comb begin
        grant_c = 2'b00;
        other   = ~ptr_q;
        if (req[ptr_q])      grant_c[ptr_q] = 1'b1;
        else if (req[other]) grant_c[other] = 1'b1;
    end
endmodule

// File: rtl/tx_frame_sched.sv
// Arbitrates requesters A (1 byte) and B (B_BYTES bytes) onto one UART TX,
// serialising each frame over the data_valid/busy handshake.
// Optional: TX_SCHED_TIMEOUT_EN adds a tx_busy rise timeout that aborts the frame.
module tx_frame_sched
    import tx_sched_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned B_BYTES = B_BYTES_DEF
`ifdef TX_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
) (
    input logic             clk,
    input logic             rst,
    tx_frame_sched_if.slave bus
);
    localparam int unsigned BUF_W = DATA_W * B_BYTES;
    localparam int unsigned IDX_W = (B_BYTES > 1) ? $clog2(B_BYTES) : 1;
`ifdef TX_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
`endif

    state_e             state_q, state_next;
    logic [BUF_W-1:0]   buf_q, buf_next;
    logic [IDX_W-1:0]   idx_q, idx_next;
    logic [IDX_W:0]     cnt_q, cnt_next;
    logic               id_q, id_next;
    logic               a_ack_next, b_ack_next, arb_update;
    logic [1:0]         grant_c;
    logic [DATA_W-1:0]  byte_sel, tx_p_data_next;
    logic               a_ack_q, b_ack_q, tx_valid_q, idle_q;
    logic [DATA_W-1:0]  tx_p_data_q;
`ifdef TX_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_q, tmo_next;
    logic               err_next, err_q;
`endif

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.b_req, bus.a_req}),
        .update  (arb_update),
        .upd_id  (id_q),
        .grant_c (grant_c)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_next;
    end

    // Next state, frame capture, byte sequencing and ack generation.
    always_comb begin
        state_next = state_q;
        buf_next   = buf_q;
        idx_next   = idx_q;
        cnt_next   = cnt_q;
        id_next    = id_q;
        a_ack_next = 1'b0;
        b_ack_next = 1'b0;
        arb_update = 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
        tmo_next   = tmo_q;
        err_next   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A busy transmitter is in external use; requests are not sampled.
                if (!bus.tx_busy && (bus.a_req || bus.b_req)) begin
                    state_next = SEND;
                    idx_next   = '0;
                    if (grant_c[REQ_B]) begin
                        id_next    = REQ_B;
                        buf_next   = bus.b_data;
                        cnt_next   = (IDX_W+1)'(B_BYTES);
                        b_ack_next = 1'b1;
                    end else begin
                        id_next    = REQ_A;
                        buf_next   = BUF_W'(bus.a_data);
                        cnt_next   = (IDX_W+1)'(1);
                        a_ack_next = 1'b1;
                    end
                end
            end
            SEND: begin
                state_next = WAIT_BUSY;
`ifdef TX_SCHED_TIMEOUT_EN
                tmo_next   = '0;
`endif
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end
`ifdef TX_SCHED_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    arb_update = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    tmo_next = tmo_q + TMO_W'(1);
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (({1'b0, idx_q} + (IDX_W+1)'(1)) < cnt_q) begin
                        idx_next   = idx_q + IDX_W'(1);
                        state_next = SEND;
                    end else begin
                        state_next = IDLE;
                        arb_update = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte presented to the transmitter in the upcoming SEND cycle.
    always_comb begin
        byte_sel = '0;
        for (int unsigned i = 0; i < B_BYTES; i++) begin
            if (idx_next == IDX_W'(i)) byte_sel = buf_next[i*DATA_W +: DATA_W];
        end
        tx_p_data_next = (state_next == SEND) ? byte_sel : tx_p_data_q;
    end

    // Frame buffer, byte index/count, winner ID and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            id_q  <= REQ_A;
`ifdef TX_SCHED_TIMEOUT_EN
            tmo_q <= '0;
`endif
        end else begin
            buf_q <= buf_next;
            idx_q <= idx_next;
            cnt_q <= cnt_next;
            id_q  <= id_next;
`ifdef TX_SCHED_TIMEOUT_EN
            tmo_q <= tmo_next;
`endif
        end
    end

    // Registered outputs, all derived from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_p_data_q <= '0;
            idle_q      <= 1'b1;
`ifdef TX_SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            a_ack_q     <= a_ack_next;
            b_ack_q     <= b_ack_next;
            tx_valid_q  <= (state_next == SEND);
            tx_p_data_q <= tx_p_data_next;
            idle_q      <= (state_next == IDLE);
`ifdef TX_SCHED_TIMEOUT_EN
            err_q       <= err_next;
`endif
        end
    end

    assign bus.a_ack         = a_ack_q;
    assign bus.b_ack         = b_ack_q;
    assign bus.tx_data_valid = tx_valid_q;
    assign bus.tx_p_data     = tx_p_data_q;
    assign bus.sched_idle    = idle_q;
`ifdef TX_SCHED_TIMEOUT_EN
    assign bus.tx_err        = err_q;
`else
    assign bus.tx_err        = 1'b0;
`endif
endmodule

// File: tb/tb_tx_frame_sched.sv
// Testbench for tx_frame_sched: queue-driven requesters, a transmitter model,
// and an arbitration reference model that predicts the byte and grant streams.
module tb_tx_frame_sched;
    logic clk;
    logic rst;
    logic model_busy;
    logic force_busy;
    logic tx_en;
    int   bdly;
    int   flen;
    int   errors;
    int   checks;
    int   err_seen;

    logic [7:0]  a_q[$];
    logic [15:0] b_q[$];
    logic [7:0]  ea[$];
    logic [15:0] eb[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  got_bytes[$];
    logic        exp_acks[$];
    logic        got_acks[$];
    logic        m_ptr;

    tx_frame_sched_if ifc ();

    assign ifc.tx_busy = model_busy | force_busy;

    tx_frame_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Requesters: each holds req while its queue is non-empty, popping on ack.
    initial begin
        ifc.a_req = 1'b0; ifc.a_data = 8'h00;
        ifc.b_req = 1'b0; ifc.b_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (ifc.a_ack && a_q.size() > 0) void'(a_q.pop_front());
            if (ifc.b_ack && b_q.size() > 0) void'(b_q.pop_front());
            ifc.a_req  = (a_q.size() > 0);
            ifc.a_data = (a_q.size() > 0) ? a_q[0] : 8'h00;
            ifc.b_req  = (b_q.size() > 0);
            ifc.b_data = (b_q.size() > 0) ? b_q[0] : 16'h0000;
        end
    end

    // Transmitter: busy rises bdly cycles after a strobe and stays up flen cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.tx_data_valid && tx_en) begin
                repeat (bdly - 1) @(negedge clk);
                model_busy = 1'b1;
                repeat (flen) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: record strobed bytes and acks; a strobe must never overlap busy.
    initial begin
        err_seen = 0;
        forever begin
            @(negedge clk);
            if (ifc.tx_data_valid) begin
                got_bytes.push_back(ifc.tx_p_data);
                chk("valid_while_busy", 32'(ifc.tx_busy), 32'd0);
            end
            if (ifc.a_ack || ifc.b_ack) begin
                got_acks.push_back(ifc.b_ack);
                chk("ack_with_valid", 32'(ifc.tx_data_valid), 32'd1);
                chk("ack_exclusive", 32'(ifc.a_ack & ifc.b_ack), 32'd0);
            end
            if (ifc.tx_err) err_seen++;
        end
    end

    task automatic push_a(input logic [7:0] d);
        a_q.push_back(d);
        ea.push_back(d);
    endtask

    task automatic push_b(input logic [15:0] d);
        b_q.push_back(d);
        eb.push_back(d);
    endtask

    // Reference: pending items served favoured-first, pointer then favours the loser.
    task automatic model_run();
        logic        w;
        logic [15:0] f;
        while (ea.size() > 0 || eb.size() > 0) begin
            if (m_ptr == 1'b0) w = (ea.size() > 0) ? 1'b0 : 1'b1;
            else               w = (eb.size() > 0) ? 1'b1 : 1'b0;
            exp_acks.push_back(w);
            if (!w) begin
                exp_bytes.push_back(ea.pop_front());
            end else begin
                f = eb.pop_front();
                exp_bytes.push_back(f[7:0]);
                exp_bytes.push_back(f[15:8]);
            end
            m_ptr = ~w;
        end
    endtask

    task automatic wait_done(input string tag);
        int stable = 0;
        int n = 0;
        while (stable < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (ifc.sched_idle && a_q.size() == 0 && b_q.size() == 0 && !model_busy && !force_busy)
                stable++;
            else
                stable = 0;
        end
        chk({tag, "_done"}, 32'(stable >= 4), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
        chk({tag, "_nacks"}, 32'(got_acks.size()), 32'(exp_acks.size()));
        for (int i = 0; i < exp_acks.size() && i < got_acks.size(); i++)
            chk($sformatf("%s_ack%0d", tag, i), 32'(got_acks[i]), 32'(exp_acks[i]));
        got_bytes.delete(); exp_bytes.delete();
        got_acks.delete();  exp_acks.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_ack"}, 32'(ifc.a_ack), 32'd0);
        chk({tag, "_b_ack"}, 32'(ifc.b_ack), 32'd0);
        chk({tag, "_tx_p_data"}, 32'(ifc.tx_p_data), 32'd0);
        chk({tag, "_tx_valid"}, 32'(ifc.tx_data_valid), 32'd0);
        chk({tag, "_sched_idle"}, 32'(ifc.sched_idle), 32'd1);
        chk({tag, "_tx_err"}, 32'(ifc.tx_err), 32'd0);
    endtask

    initial begin
        int n;
        int na;
        int nb;
        errors = 0; checks = 0;
        rst = 1'b1; force_busy = 1'b0; tx_en = 1'b1;
        bdly = 2; flen = 10; m_ptr = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single A byte: ack and strobe one cycle after the request is sampled.
        @(posedge clk); #1;
        push_a(8'h5A);
        @(posedge clk); #1;
        chk("a1_ack_latency", 32'(ifc.a_ack), 32'd1);
        chk("a1_valid_latency", 32'(ifc.tx_data_valid), 32'd1);
        chk("a1_data", 32'(ifc.tx_p_data), 32'h5A);
        model_run();
        wait_done("a1");
        compare_stream("a1");

        // Single B frame: low byte first.
        @(posedge clk); #1;
        push_b(16'hBEEF);
        model_run();
        wait_done("b1");
        compare_stream("b1");

        // Busy held by an external user: request must not be taken.
        @(posedge clk); #1;
        force_busy = 1'b1;
        push_a(8'h77);
        repeat (15) @(negedge clk);
        chk("prebusy_no_ack", 32'(got_acks.size()), 32'd0);
        chk("prebusy_no_valid", 32'(got_bytes.size()), 32'd0);
        chk("prebusy_idle", 32'(ifc.sched_idle), 32'd1);
        force_busy = 1'b0;
        model_run();
        wait_done("prebusy");
        compare_stream("prebusy");

        // Randomized request mixes and transmitter timing.
        for (int r = 0; r < 6; r++) begin
            bdly = int'($urandom_range(1, 4));
            flen = int'($urandom_range(1, 6));
            na = int'($urandom_range(0, 3));
            nb = int'($urandom_range(0, 3));
            if (na + nb == 0) na = 1;
            @(posedge clk); #1;
            for (int i = 0; i < na; i++) push_a(8'($urandom_range(0, 255)));
            for (int i = 0; i < nb; i++) push_b(16'($urandom_range(0, 65535)));
            model_run();
            wait_done($sformatf("rnd%0d", r));
            compare_stream($sformatf("rnd%0d", r));
        end

        // Reset during WAIT_DONE of B byte 0.
        bdly = 2; flen = 8;
        @(posedge clk); #1;
        push_b(16'hC3A5);
        eb.delete();
        exp_bytes.push_back(8'hA5);
        exp_acks.push_back(1'b1);
        n = 0;
        while (!model_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_busy_seen", 32'(model_busy), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 1'b0;
        wait_done("midrst");
        repeat (10) @(negedge clk);
        compare_stream("midrst");

        // Contention out of reset: strict A,B alternation starting with A.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            push_a(8'($urandom_range(0, 255)));
            push_b(16'($urandom_range(0, 65535)));
        end
        model_run();
        wait_done("contend");
        compare_stream("contend");

`ifdef TX_SCHED_TIMEOUT_EN
        // Transmitter never raises busy: error pulse, frame dropped.
        tx_en = 1'b0;
        @(posedge clk); #1;
        push_b(16'h1234);
        n = 0;
        while (!ifc.tx_data_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_valid_seen", 32'(ifc.tx_data_valid), 32'd1);
        n = 0;
        while (!ifc.tx_err && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd17);
        chk("tmo_idle", 32'(ifc.sched_idle), 32'd1);
        @(posedge clk); #1;
        chk("tmo_err_pulse", 32'(ifc.tx_err), 32'd0);
        eb.delete();
        exp_bytes.push_back(8'h34);
        exp_acks.push_back(1'b1);
        m_ptr = 1'b0;
        wait_done("tmo");
        repeat (20) @(negedge clk);
        compare_stream("tmo");
        tx_en = 1'b1;
        chk("tx_err_count", 32'(err_seen), 32'd1);
`else
        chk("tx_err_never", 32'(err_seen), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
- Sequencer and arbiter in front of the UART transmitter.
- Shares the single UART TX between two requesters:
  - A: one-byte register-read responses.
  - B: two-byte ALU results.
- Each grant is serialised into back-to-back byte transfers using the transmitter's data_valid/busy handshake.
- Sits between the system controller and the UART TX, in the UART clock domain.

Parameters:
- DATA_W, 8, byte width driven to the transmitter.
- B_BYTES, 2, bytes per requester-B frame; B data width is DATA_W*B_BYTES.
- TIMEOUT, 16, cycles allowed for tx_busy to rise after a byte is issued (used only with the optional feature).

Ports:
- clk  in  1  UART TX clock.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A has a byte pending (level).
- a_data  in  DATA_W  requester A byte.
- a_ack  out  1  one-cycle pulse: a_data captured.
- b_req  in  1  requester B has a frame pending (level).
- b_data  in  DATA_W*B_BYTES  requester B frame, byte 0 = bits [DATA_W-1:0].
- b_ack  out  1  one-cycle pulse: b_data captured.
- tx_p_data  out  DATA_W  byte to transmitter.
- tx_data_valid  out  1  one-cycle strobe to transmitter.
- tx_busy  in  1  transmitter busy.
- sched_idle  out  1  high when the FSM is in IDLE.
- tx_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM to IDLE, buffer and byte counter cleared, round-robin pointer set to favour A.
  - All outputs registered; reset values: a_ack=0, b_ack=0, tx_p_data=0, tx_data_valid=0, sched_idle=1, tx_err=0.
  - Reset mid-frame discards the frame; no ack is re-issued.
- FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Leaves only when tx_busy=0 and (a_req or b_req).
  - Winner is the requester favoured by the round-robin pointer if it requests, otherwise the other one.
  - On the exit edge: winner's data latched, byte count loaded (A=1, B=B_BYTES), byte index=0, winner's ack asserted for the next cycle only.
- SEND (exactly 1 cycle):
  - tx_data_valid=1 and tx_p_data=buffer byte[index]. Next state is WAIT_BUSY.
  - So ack and the first tx_data_valid occur in the same cycle, one cycle after the request was sampled.
- WAIT_BUSY: hold until tx_busy=1, then go to WAIT_DONE. tx_data_valid=0.
- WAIT_DONE: hold until tx_busy=0. Then:
  - If bytes remain: index+1, back to SEND.
  - Otherwise: go to IDLE and toggle the pointer to favour the non-winner.
- Byte order for B: byte 0 first, ascending.
- Requesters must drop req on the cycle after ack. A req still high when IDLE is re-entered is treated as a new request.
- Both requesting together: pointer decides. Continuous requests from both strictly alternate A,B,A,B.
- Request arriving mid-frame: waits; it is not captured until IDLE.
- tx_busy already high in IDLE (external use of the transmitter): stay in IDLE, do not sample requests.
- sched_idle equals (state==IDLE), registered.

Optional Feature:
- Macro: TX_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY.
  - If tx_busy has not risen after TIMEOUT cycles: pulse tx_err for one cycle, drop the rest of the frame, return to IDLE and toggle the pointer.
  - The counter clears on entering WAIT_BUSY.
- Undefined: WAIT_BUSY waits indefinitely; tx_err is tied to 0 and no counter is built.

Decomposition:
- Package tx_sched_pkg holds:
  - state encoding constants IDLE/SEND/WAIT_BUSY/WAIT_DONE;
  - requester ID constants REQ_A=0 and REQ_B=1;
  - default widths.
- One sub-module, rr_arb2: a two-way round-robin arbiter with a pointer-update input. It provides grant only and holds no data path.
- Frame buffer, byte counter, timeout counter and FSM live in tx_frame_sched.

Test Plan:
- A single byte:
  - Stimulus: a_req=1, a_data=0x5A, transmitter model asserts busy 2 cycles after valid, 10-cycle frame.
  - Response: a_ack one cycle later, tx_p_data=0x5A with a single tx_data_valid, back to IDLE after busy falls.
- B single frame:
  - Stimulus: b_data=0xBEEF.
  - Response: two strobes, 0xEF then 0xBE; b_ack once; second valid only after busy falls.
- Contention:
  - Stimulus: a_req and b_req both held high out of reset.
  - Response: grant order A, B, A, B; each ack coincides with its first valid.
- Busy pre-asserted:
  - Stimulus: tx_busy=1 while a_req=1.
  - Response: no ack and no valid until tx_busy falls; then normal sequence.
- Reset mid-frame:
  - Stimulus: rst pulsed during WAIT_DONE of B byte 0.
  - Response: all outputs at reset values, second byte never sent, A favoured next.
- Timeout (macro defined, TIMEOUT=16):
  - Stimulus: transmitter never raises busy.
  - Response: tx_err pulses 16 cycles after entering WAIT_BUSY; IDLE next; remaining B byte not sent.
